instruction_fetch_ctrl: RTL and testbench

Fetch sequencer for the synchronous-read instruction memory. The memory registers its output on each clk edge from the address presented in the previous cycle.
- Owns the program counter and drives the memory address.
- Tracks the 1-cycle read latency and squashes in-flight reads on redirect.
- Presents instructions to decode through a valid/ready handshake, with a 1-entry skid buffer so decode back-pressure never drops or duplicates an instruction.

---
 rtl/instruction_fetch_ctrl_pkg.sv | 9 +
 rtl/fetch_skid_buffer.sv | 36 +++
 rtl/instruction_fetch_ctrl.sv | 86 ++++++++
 tb/tb_instruction_fetch_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_ctrl_pkg.sv
// Shared fetch constants: word size, reset vector, sequential PC step and the NOP encoding.
package instruction_fetch_ctrl_pkg;

    localparam int                      IF_WORD_SIZE    = 32;
    localparam logic [IF_WORD_SIZE-1:0] IF_RESET_VECTOR = 32'h0000_0000;
    localparam int                      IF_PC_STEP      = 4;
    localparam logic [IF_WORD_SIZE-1:0] IF_NOP_INSTR    = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction/PC pair that decode could not accept.
module fetch_skid_buffer
    import instruction_fetch_ctrl_pkg::*;
#(
    parameter int W = IF_WORD_SIZE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  logic         pop,
    input  logic [W-1:0] load_instr,
    input  logic [W-1:0] load_pc,
    output logic         valid,
    output logic [W-1:0] instr,
    output logic [W-1:0] pc
);

    // Flush beats load beats pop; data regs are cleared on reset so outputs stay X-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_ctrl.sv
// Fetch sequencer: owns the PC, tracks the 1-cycle synchronous imem read, and hands
// instructions to decode over valid/ready with a skid entry absorbing back-pressure.
module instruction_fetch_ctrl
    import instruction_fetch_ctrl_pkg::*;
#(
    parameter int                   WORD_SIZE    = IF_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = IF_RESET_VECTOR,
    parameter int                   PC_STEP      = IF_PC_STEP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_en,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic [WORD_SIZE-1:0] imem_instruction,
    output logic                 if_valid,
    input  logic                 if_ready,
    output logic [WORD_SIZE-1:0] if_instr,
    output logic [WORD_SIZE-1:0] if_pc
);

    logic [WORD_SIZE-1:0] pc;
    logic                 inflight;
    logic [WORD_SIZE-1:0] inflight_pc;

    logic                 skid_valid;
    logic [WORD_SIZE-1:0] skid_instr;
    logic [WORD_SIZE-1:0] skid_pc;

    logic                 xfer;
    logic                 skid_next;
    logic                 skid_load;
    logic                 skid_pop;
    logic                 issue;
    logic [WORD_SIZE-1:0] redirect_target;

    assign imem_addr = pc;

    always_comb begin
        if_valid  = (inflight | skid_valid) & ~redirect_valid & ~rst;
        if_instr  = skid_valid ? skid_instr : imem_instruction;
        if_pc     = skid_valid ? skid_pc    : inflight_pc;
        xfer      = if_valid & if_ready;
        skid_next = if_valid & ~if_ready;
        // A stalled cycle must not issue: the read data would have nowhere to go.
        issue     = fetch_en & ~skid_next & ~redirect_valid;
        skid_load = skid_next & ~skid_valid;
        skid_pop  = skid_valid & xfer;
    end

    assign redirect_target = redirect_pc & ~WORD_SIZE'(3);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_VECTOR;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_target;
            inflight <= 1'b0;
        end else if (issue) begin
            pc          <= pc + WORD_SIZE'(PC_STEP);
            inflight    <= 1'b1;
            inflight_pc <= pc;
        end else begin
            inflight <= 1'b0;
        end
    end

    fetch_skid_buffer #(
        .W(WORD_SIZE)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .load       (skid_load),
        .pop        (skid_pop),
        .load_instr (if_instr),
        .load_pc    (if_pc),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Directed bench for instruction_fetch_ctrl with a 1-cycle synchronous imem model.
module tb_instruction_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instruction = 32'h0;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_en         (fetch_en),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_addr        (imem_addr),
        .imem_instruction (imem_instruction),
        .if_valid         (if_valid),
        .if_ready         (if_ready),
        .if_instr         (if_instr),
        .if_pc            (if_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h1111_1111;
            32'h4:   return 32'h2222_2222;
            32'h8:   return 32'h3333_3333;
            default: return ~a;
        endcase
    endfunction

    always @(posedge clk) imem_instruction <= mem_word(imem_addr);

    // Start a new cycle: drive inputs just after the edge, then wait to the sampling point.
    task automatic cyc(input logic fe, input logic rv, input logic [31:0] rpc,
                       input logic rdy, input logic rs);
        @(posedge clk); #1;
        fetch_en = fe; redirect_valid = rv; redirect_pc = rpc; if_ready = rdy; rst = rs;
        @(negedge clk);
    endtask

    task automatic test_reset;
        cyc(0, 0, 0, 1, 1);
        cyc(1, 0, 0, 1, 1);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", if_valid); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 00000000", imem_addr); end
        checks++; if ($isunknown({if_instr, if_pc})) begin errors++; $display("FAIL reset_xfree: instr %h pc %h exp known", if_instr, if_pc); end
    endtask

    task automatic test_stream;
        cyc(1, 0, 0, 1, 0); // cycle 0
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL c0_addr: got %h exp 00000000", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL c0_valid: got %b exp 0", if_valid); end
        cyc(1, 0, 0, 1, 0); // cycle 1
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL c1_addr: got %h exp 00000004", imem_addr); end
        checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 32'h1111_1111}) begin errors++; $display("FAIL c1_out: got v%b pc %h i %h exp v1 pc 00000000 i 11111111", if_valid, if_pc, if_instr); end
        cyc(1, 0, 0, 1, 0); // cycle 2
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL c2_addr: got %h exp 00000008", imem_addr); end
        checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h4, 32'h2222_2222}) begin errors++; $display("FAIL c2_out: got v%b pc %h i %h exp v1 pc 00000004 i 22222222", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_stall;
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 0, 0, 0); // cycles 3..5, decode stalled
            checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h8, 32'h3333_3333}) begin errors++; $display("FAIL stall_out k%0d: got v%b pc %h i %h exp v1 pc 00000008 i 33333333", k, if_valid, if_pc, if_instr); end
            checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL stall_addr k%0d: got %h exp 0000000c", k, imem_addr); end
        end
        cyc(1, 0, 0, 1, 0); // cycle 6, ready returns
        checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h8, 32'h3333_3333}) begin errors++; $display("FAIL resume_out: got v%b pc %h i %h exp v1 pc 00000008 i 33333333", if_valid, if_pc, if_instr); end
        checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL resume_addr: got %h exp 0000000c", imem_addr); end
        cyc(1, 0, 0, 1, 0); // cycle 7
        checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'hC, 32'hFFFF_FFF3}) begin errors++; $display("FAIL after_stall_out: got v%b pc %h i %h exp v1 pc 0000000c i fffffff3", if_valid, if_pc, if_instr); end
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL after_stall_addr: got %h exp 00000010", imem_addr); end
    endtask

    task automatic test_redirect;
        cyc(1, 1, 32'h40, 1, 0);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_n_valid: got %b exp 0", if_valid); end
        cyc(1, 0, 0, 1, 0);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_n1_valid: got %b exp 0", if_valid); end
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL redir_n1_addr: got %h exp 00000040", imem_addr); end
        cyc(1, 0, 0, 1, 0);
        checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h40, 32'hFFFF_FFBF}) begin errors++; $display("FAIL redir_n2_out: got v%b pc %h i %h exp v1 pc 00000040 i ffffffbf", if_valid, if_pc, if_instr); end
        checks++; if (imem_addr !== 32'h44) begin errors++; $display("FAIL redir_n2_addr: got %h exp 00000044", imem_addr); end
    endtask

    task automatic test_redirect_held;
        cyc(1, 1, 32'h10, 1, 0);
        cyc(1, 0, 0, 1, 0);
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL held_setup_addr: got %h exp 00000010", imem_addr); end
        cyc(1, 0, 0, 0, 0); // 0x10 valid but decode stalled -> captured into skid
        checks++; if ({if_valid, if_pc} !== {1'b1, 32'h10}) begin errors++; $display("FAIL held_setup_out: got v%b pc %h exp v1 pc 00000010", if_valid, if_pc); end
        cyc(1, 1, 32'h83, 0, 0); // redirect while held
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL held_redir_valid: got %b exp 0", if_valid); end
        cyc(1, 0, 0, 1, 0);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL held_flush_valid: got %b pc %h exp 0", if_valid, if_pc); end
        checks++; if (imem_addr !== 32'h80) begin errors++; $display("FAIL held_redir_addr: got %h exp 00000080", imem_addr); end
        cyc(1, 0, 0, 1, 0);
        checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h80, 32'hFFFF_FF7F}) begin errors++; $display("FAIL held_next_out: got v%b pc %h i %h exp v1 pc 00000080 i ffffff7f", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_reset_in_stall;
        cyc(1, 0, 0, 0, 0); // 0x84 stalls into skid
        checks++; if ({if_valid, if_pc} !== {1'b1, 32'h84}) begin errors++; $display("FAIL rstall_setup: got v%b pc %h exp v1 pc 00000084", if_valid, if_pc); end
        cyc(1, 0, 0, 0, 1);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rstall_valid: got %b exp 0", if_valid); end
        cyc(1, 0, 0, 1, 0);
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rstall_addr: got %h exp 00000000", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rstall_post_valid: got %b exp 0", if_valid); end
        cyc(1, 0, 0, 1, 0);
        checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 32'h1111_1111}) begin errors++; $display("FAIL rstall_first: got v%b pc %h i %h exp v1 pc 00000000 i 11111111", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_wrap_and_fetch_en;
        cyc(1, 1, 32'hFFFF_FFFC, 1, 0);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL wrap_redir_valid: got %b exp 0", if_valid); end
        cyc(1, 0, 0, 1, 0);
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h exp fffffffc", imem_addr); end
        cyc(1, 0, 0, 1, 0);
        checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'hFFFF_FFFC, 32'h3}) begin errors++; $display("FAIL wrap_top_out: got v%b pc %h i %h exp v1 pc fffffffc i 00000003", if_valid, if_pc, if_instr); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_mod_addr: got %h exp 00000000", imem_addr); end
        cyc(0, 0, 0, 1, 0); // fetch_en drops; in-flight 0x0 still delivered
        checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 32'h1111_1111}) begin errors++; $display("FAIL drain_out: got v%b pc %h i %h exp v1 pc 00000000 i 11111111", if_valid, if_pc, if_instr); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL drain_addr: got %h exp 00000004", imem_addr); end
        cyc(0, 0, 0, 1, 0);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b exp 0", if_valid); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL idle_addr: got %h exp 00000004", imem_addr); end
        cyc(1, 0, 0, 1, 0); // fetch_en rises: held pc issues immediately
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rise_valid: got %b exp 0", if_valid); end
        cyc(1, 0, 0, 1, 0);
        checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h4, 32'h2222_2222}) begin errors++; $display("FAIL rise_out: got v%b pc %h i %h exp v1 pc 00000004 i 22222222", if_valid, if_pc, if_instr); end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL rise_addr: got %h exp 00000008", imem_addr); end
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b1;
        test_reset;
        test_stream;
        test_stall;
        test_redirect;
        test_redirect_held;
        test_reset_in_stall;
        test_wrap_and_fetch_en;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
